can_tx_scheduler: RTL and testbench
===================================

// Module: can_tx_scheduler
// PURPOSE
//  Schedules CAN transmission from a high-priority and a normal-priority Tx FIFO (fifo instances,
//  DATA_WIDTH-bit frames) into the bit-stream transmit engine. Pops one frame at a time, holds it
//  through arbitration/error retries, reports completion or abort. Sits between the host-side
//  Tx FIFOs and the CAN Tx engine; FIFO read data is registered (valid 1 cycle after rd_en).
// PARAMETERS
//  DATA_WIDTH   128  frame width (matches Tx FIFO word)
//  RETRY_LIMIT  16   error retries before a frame is aborted (>=1)
//  MAX_HI_RUN   4    consecutive hi frames allowed while lo pending (anti-starvation, >=1)
// PORTS
//  i_sys_clk      in   1           system clock
//  i_reset        in   1           synchronous, active-high reset
//  i_enable       in   1           1 = scheduler may start new frames
//  i_hi_empty     in   1           hi FIFO o_empty
//  o_hi_rd_en     out  1           hi FIFO i_r_en (1-cycle pulse)
//  i_hi_data      in   DATA_WIDTH  hi FIFO o_fifo_r_data
//  i_lo_empty     in   1           lo FIFO o_empty
//  o_lo_rd_en     out  1           lo FIFO i_r_en (1-cycle pulse)
//  i_lo_data      in   DATA_WIDTH  lo FIFO o_fifo_r_data
//  o_frame        out  DATA_WIDTH  frame to Tx engine, stable while o_frame_valid
//  o_frame_valid  out  1           frame offered to Tx engine
//  i_frame_ready  in   1           Tx engine accepts frame (handshake = valid & ready)
//  i_tx_done      in   1           pulse: frame sent and ACKed
//  i_arb_lost     in   1           pulse: arbitration lost, retry without count
//  i_tx_error     in   1           pulse: bus/ACK error, counted retry
//  o_tx_ok        out  1           pulse: frame completed
//  o_tx_abort     out  1           pulse: frame dropped after RETRY_LIMIT errors
//  o_src          out  1           source of held frame (1 = hi, 0 = lo)
//  o_retry_cnt    out  $clog2(RETRY_LIMIT+1)  error retries on held frame
//  o_busy         out  1           state != IDLE
// BEHAVIOUR
//  Reset: all outputs 0, o_frame = 0, state IDLE, hi-run counter 0. Reset mid-frame discards
//   the held frame (already popped) with no o_tx_ok/o_tx_abort pulse.
//  FSM: IDLE -> POP -> LOAD -> OFFER -> WAIT -> (OFFER | IDLE).
//  IDLE: if i_enable & (!i_hi_empty | !i_lo_empty): select source, go POP. Selection: hi if
//   hi non-empty and (lo empty or hi_run < MAX_HI_RUN); else lo. Both empty/disabled: stay.
//  POP (1 cycle): assert selected rd_en only; latch o_src.
//  LOAD (1 cycle): capture selected i_*_data into o_frame; o_retry_cnt <= 0.
//  OFFER: o_frame_valid = 1 until cycle with i_frame_ready = 1, then WAIT (valid drops next cycle).
//  WAIT: event priority when simultaneous: done > error > arb_lost.
//   done: o_tx_ok pulse 1 cycle, -> IDLE; hi_run <= src ? hi_run+1 (saturate) : 0.
//   error: if o_retry_cnt == RETRY_LIMIT-1: o_tx_abort pulse, -> IDLE (hi_run updated as done);
//    else o_retry_cnt+1, -> OFFER.
//   arb_lost: -> OFFER, count unchanged.
//  Events outside WAIT are ignored. i_enable low does not interrupt a held frame.
//  Min latency non-empty FIFO -> o_frame_valid: 3 cycles (IDLE sample, POP, LOAD).
//  Exactly one rd_en per frame; never rd_en on an empty FIFO; o_frame constant POP..IDLE.
// TESTING
//  Hi empty, lo holds A; ready tied 1, done 2 cycles after handshake -> one lo_rd_en, o_frame=A,
//   valid 3 cycles after enable, o_tx_ok once, o_src=0.
//  Hi holds 6 frames, lo holds 2, MAX_HI_RUN=4, all done -> order H H H H L H H L.
//  Error x15 then done (RETRY_LIMIT=16) -> o_retry_cnt reaches 15, o_tx_ok, no abort.
//  Error x16 -> o_tx_abort after 16th, o_retry_cnt=15 at abort; arb_lost x50 interleaved -> count unaffected.
//  done+error same cycle -> o_tx_ok only; reset during WAIT -> all outputs 0 next cycle, no pulses.
//  i_frame_ready held 0 for 20 cycles -> o_frame_valid and o_frame stable throughout.

Source files
------------

// File: rtl/can_tx_scheduler.sv
// CAN transmit scheduler.
// Pulls one frame at a time from a high- or normal-priority Tx FIFO and offers it
// to the CAN Tx engine. The frame is held across arbitration losses and error
// retries, and completion or abort is reported as a single-cycle pulse. A run
// counter limits back-to-back hi frames while lo traffic waits.
module can_tx_scheduler #(
   parameter int DATA_WIDTH  = 128,
   parameter int RETRY_LIMIT = 16,
   parameter int MAX_HI_RUN  = 4
) (
   input  logic                               i_sys_clk,
   input  logic                               i_reset,
   input  logic                               i_enable,
   input  logic                               i_hi_empty,
   output logic                               o_hi_rd_en,
   input  logic [DATA_WIDTH-1:0]              i_hi_data,
   input  logic                               i_lo_empty,
   output logic                               o_lo_rd_en,
   input  logic [DATA_WIDTH-1:0]              i_lo_data,
   output logic [DATA_WIDTH-1:0]              o_frame,
   output logic                               o_frame_valid,
   input  logic                               i_frame_ready,
   input  logic                               i_tx_done,
   input  logic                               i_arb_lost,
   input  logic                               i_tx_error,
   output logic                               o_tx_ok,
   output logic                               o_tx_abort,
   output logic                               o_src,
   output logic [$clog2(RETRY_LIMIT+1)-1:0]   o_retry_cnt,
   output logic                               o_busy
);

   localparam int CNT_W = $clog2(RETRY_LIMIT + 1);
   localparam int RUN_W = $clog2(MAX_HI_RUN + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_POP,
      ST_LOAD,
      ST_OFFER,
      ST_WAIT
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [RUN_W-1:0] hi_run;
   logic             start_frame;
   logic             pick_hi;
   logic             last_retry;
   logic             ev_done;
   logic             ev_abort;
   logic             ev_retry;

   // A new frame may start when enabled and either FIFO has data. Hi wins unless
   // it has already used up its run while lo is waiting.
   assign start_frame = i_enable && (!i_hi_empty || !i_lo_empty);
   assign pick_hi     = !i_hi_empty && (i_lo_empty || (hi_run < RUN_W'(MAX_HI_RUN)));
   assign last_retry  = (o_retry_cnt == CNT_W'(RETRY_LIMIT - 1));

   // Next-state and event decode; in WAIT, done beats error beats arbitration loss.
   always_comb begin
      state_nxt = state;
      ev_done   = 1'b0;
      ev_abort  = 1'b0;
      ev_retry  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start_frame) begin
               state_nxt = ST_POP;
            end
         end
         ST_POP: begin
            state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            state_nxt = ST_OFFER;
         end
         ST_OFFER: begin
            if (i_frame_ready) begin
               state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (i_tx_done) begin
               ev_done   = 1'b1;
               state_nxt = ST_IDLE;
            end else if (i_tx_error) begin
               if (last_retry) begin
                  ev_abort  = 1'b1;
                  state_nxt = ST_IDLE;
               end else begin
                  ev_retry  = 1'b1;
                  state_nxt = ST_OFFER;
               end
            end else if (i_arb_lost) begin
               state_nxt = ST_OFFER;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // State register; a reset anywhere drops the held frame without reporting it.
   always_ff @(posedge i_sys_clk) begin
      if (i_reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Datapath: read pulses during POP, frame capture in LOAD, retry count,
   // completion pulses and the hi-run counter.
   always_ff @(posedge i_sys_clk) begin
      if (i_reset) begin
         o_hi_rd_en  <= 1'b0;
         o_lo_rd_en  <= 1'b0;
         o_src       <= 1'b0;
         o_frame     <= '0;
         o_retry_cnt <= '0;
         o_tx_ok     <= 1'b0;
         o_tx_abort  <= 1'b0;
         hi_run      <= '0;
      end else begin
         o_hi_rd_en <= (state == ST_IDLE) && start_frame && pick_hi;
         o_lo_rd_en <= (state == ST_IDLE) && start_frame && !pick_hi;
         o_tx_ok    <= ev_done;
         o_tx_abort <= ev_abort;
         if ((state == ST_IDLE) && start_frame) begin
            o_src <= pick_hi;
         end
         if (state == ST_LOAD) begin
            o_frame     <= o_src ? i_hi_data : i_lo_data;
            o_retry_cnt <= '0;
         end
         if (ev_retry) begin
            o_retry_cnt <= o_retry_cnt + CNT_W'(1);
         end
         if (ev_done || ev_abort) begin
            if (o_src) begin
               if (hi_run != RUN_W'(MAX_HI_RUN)) begin
                  hi_run <= hi_run + RUN_W'(1);
               end
            end else begin
               hi_run <= '0;
            end
         end
      end
   end

   assign o_frame_valid = (state == ST_OFFER);
   assign o_busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Testbench for can_tx_scheduler.
// Two queue-backed FIFOs with registered read data, a scripted or random Tx
// engine, and a cycle-level reference model built from the scheduling rules.
module tb_can_tx_scheduler;

   localparam int DW  = 128;
   localparam int RL  = 16;
   localparam int MHR = 4;
   localparam int CW  = $clog2(RL + 1);

   logic          clk = 1'b0;
   logic          i_reset, i_enable, i_hi_empty, i_lo_empty;
   logic [DW-1:0] i_hi_data, i_lo_data;
   logic          i_frame_ready, i_tx_done, i_arb_lost, i_tx_error;
   logic          o_hi_rd_en, o_lo_rd_en, o_frame_valid, o_tx_ok, o_tx_abort, o_src, o_busy;
   logic [DW-1:0] o_frame;
   logic [CW-1:0] o_retry_cnt;

   // Bench FIFO contents and Tx engine script
   logic [DW-1:0] hi_q[$];
   logic [DW-1:0] lo_q[$];
   byte           script_q[$];
   bit            rand_mode, ready_low, check_en;
   int            ev_delay, fire_at, cyc_n;

   // Reference model state
   int            m_cyc;
   bit            m_acc, m_src, m_ok, m_abort, m_fin;
   int            m_retry, m_hi_run;
   logic [DW-1:0] m_frame, m_pend;

   // Tallies and logs of what the DUT reported
   int            n_vec, n_miss;
   int            n_ok, n_abort, n_hi_rd, n_lo_rd, max_retry, ok_retry, abort_retry;
   bit            ok_src_log[$];
   logic [DW-1:0] ok_frame_log[$];

   can_tx_scheduler #(.DATA_WIDTH(DW), .RETRY_LIMIT(RL), .MAX_HI_RUN(MHR)) dut (
      .i_sys_clk(clk), .i_reset(i_reset), .i_enable(i_enable),
      .i_hi_empty(i_hi_empty), .o_hi_rd_en(o_hi_rd_en), .i_hi_data(i_hi_data),
      .i_lo_empty(i_lo_empty), .o_lo_rd_en(o_lo_rd_en), .i_lo_data(i_lo_data),
      .o_frame(o_frame), .o_frame_valid(o_frame_valid), .i_frame_ready(i_frame_ready),
      .i_tx_done(i_tx_done), .i_arb_lost(i_arb_lost), .i_tx_error(i_tx_error),
      .o_tx_ok(o_tx_ok), .o_tx_abort(o_tx_abort), .o_src(o_src),
      .o_retry_cnt(o_retry_cnt), .o_busy(o_busy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] rand_word();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Model: m_cyc counts cycles since a frame was chosen (0 = nothing held);
   // from cycle 3 on the frame is either being offered or awaiting an event.
   always @(posedge clk) begin
      m_ok    = 1'b0;
      m_abort = 1'b0;
      m_fin   = 1'b0;
      if (i_reset) begin
         m_cyc = 0; m_acc = 0; m_src = 0; m_frame = '0; m_retry = 0; m_hi_run = 0;
      end else if (m_cyc == 0) begin
         if (i_enable && (hi_q.size() != 0 || lo_q.size() != 0)) begin
            m_src  = (hi_q.size() != 0) && (lo_q.size() == 0 || m_hi_run < MHR);
            m_pend = m_src ? hi_q[0] : lo_q[0];
            m_cyc  = 1;
         end
      end else if (m_cyc == 1) begin
         m_cyc = 2;
      end else if (m_cyc == 2) begin
         m_frame = m_pend; m_retry = 0; m_acc = 0; m_cyc = 3;
      end else if (!m_acc) begin
         if (i_frame_ready) m_acc = 1;
      end else begin
         if (i_tx_done) begin
            m_ok = 1; m_fin = 1;
         end else if (i_tx_error) begin
            if (m_retry == RL - 1) begin
               m_abort = 1; m_fin = 1;
            end else begin
               m_retry++; m_acc = 0;
            end
         end else if (i_arb_lost) begin
            m_acc = 0;
         end
         if (m_fin) begin
            m_hi_run = m_src ? ((m_hi_run < MHR) ? m_hi_run + 1 : MHR) : 0;
            m_cyc = 0; m_acc = 0;
         end
      end
   end

   // Compare every output against the model mid-cycle and tally reported events
   always @(negedge clk) begin
      if (check_en) begin
         checkOutput("hi_rd_en", o_hi_rd_en, (m_cyc == 1) && m_src);
         checkOutput("lo_rd_en", o_lo_rd_en, (m_cyc == 1) && !m_src);
         checkOutput("frame_valid", o_frame_valid, (m_cyc >= 3) && !m_acc);
         checkOutput("busy", o_busy, m_cyc != 0);
         checkOutput("frame", o_frame, m_frame);
         checkOutput("src", o_src, m_src);
         checkOutput("retry_cnt", o_retry_cnt, m_retry);
         checkOutput("tx_ok", o_tx_ok, m_ok);
         checkOutput("tx_abort", o_tx_abort, m_abort);
         if (o_tx_ok) begin
            n_ok++; ok_src_log.push_back(o_src); ok_frame_log.push_back(o_frame); ok_retry = o_retry_cnt;
         end
         if (o_tx_abort) begin
            n_abort++; abort_retry = o_retry_cnt;
         end
         if (o_hi_rd_en) n_hi_rd++;
         if (o_lo_rd_en) n_lo_rd++;
         if (int'(o_retry_cnt) > max_retry) max_retry = o_retry_cnt;
      end
   end

   // Drive the Tx engine and random traffic for the next cycle
   task automatic applyStimulus(input bit hs);
      i_tx_done  = 1'b0;
      i_tx_error = 1'b0;
      i_arb_lost = 1'b0;
      if (rand_mode) begin
         i_frame_ready = ($urandom_range(0, 9) < 7);
         i_tx_done     = ($urandom_range(0, 9) == 0);
         i_tx_error    = ($urandom_range(0, 9) == 0);
         i_arb_lost    = ($urandom_range(0, 9) == 0);
         i_enable      = ($urandom_range(0, 9) != 0);
         i_reset       = ($urandom_range(0, 399) == 0);
         if ($urandom_range(0, 99) < 15 && hi_q.size() < 8) hi_q.push_back(rand_word());
         if ($urandom_range(0, 99) < 15 && lo_q.size() < 8) lo_q.push_back(rand_word());
      end else begin
         i_frame_ready = !ready_low;
         if (hs) fire_at = cyc_n + ev_delay - 1;
         if (cyc_n == fire_at) begin
            byte ev;
            ev = (script_q.size() != 0) ? script_q.pop_front() : "D";
            case (ev)
               "D": i_tx_done = 1'b1;
               "E": i_tx_error = 1'b1;
               "A": i_arb_lost = 1'b1;
               "B": begin i_tx_done = 1'b1; i_tx_error = 1'b1; end
               default: i_tx_done = 1'b1;
            endcase
         end
      end
      i_hi_empty = (hi_q.size() == 0);
      i_lo_empty = (lo_q.size() == 0);
   endtask

   // One clock: FIFO pops from the read pulses of the ending cycle, then new inputs
   task automatic tick();
      bit hs, hrd, lrd;
      hs  = o_frame_valid && i_frame_ready;
      hrd = o_hi_rd_en;
      lrd = o_lo_rd_en;
      @(posedge clk);
      #1;
      cyc_n++;
      if (hrd) begin
         checkOutput("hi_rd_nonempty", hi_q.size() != 0, 1'b1);
         if (hi_q.size() != 0) i_hi_data = hi_q.pop_front();
      end
      if (lrd) begin
         checkOutput("lo_rd_nonempty", lo_q.size() != 0, 1'b1);
         if (lo_q.size() != 0) i_lo_data = lo_q.pop_front();
      end
      applyStimulus(hs);
   endtask

   task automatic push_hi(input logic [DW-1:0] d);
      hi_q.push_back(d);
      i_hi_empty = 1'b0;
   endtask

   task automatic push_lo(input logic [DW-1:0] d);
      lo_q.push_back(d);
      i_lo_empty = 1'b0;
   endtask

   task automatic reset_dut();
      i_reset = 1'b1; i_enable = 1'b0; rand_mode = 0; ready_low = 0;
      script_q.delete(); fire_at = -1; ev_delay = 1;
      tick(); tick();
      hi_q.delete(); lo_q.delete();
      i_hi_empty = 1'b1; i_lo_empty = 1'b1;
      i_reset = 1'b0;
      tick();
      n_ok = 0; n_abort = 0; n_hi_rd = 0; n_lo_rd = 0; max_retry = 0; ok_retry = -1; abort_retry = -1;
      ok_src_log.delete(); ok_frame_log.delete();
   endtask

   task automatic wait_events(input int tgt, input int bound, input string name);
      int i = 0;
      while ((n_ok + n_abort) < tgt && i < bound) begin
         tick(); i++;
      end
      checkOutput(name, (n_ok + n_abort) >= tgt, 1'b1);
      repeat (4) tick();
   endtask

   task automatic wait_valid(input int bound, output int lat);
      lat = 0;
      while (!o_frame_valid && lat < bound) begin
         tick(); lat++;
      end
   endtask

   initial begin
      #5000000;
      $display("[TB] FAIL watchdog actual=running expected=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [DW-1:0] fa, fx, f;
      logic [7:0]    order;
      int            lat, i;
      n_vec = 0; n_miss = 0; check_en = 0; cyc_n = 0; fire_at = -1; ev_delay = 1;
      i_reset = 1'b1; i_enable = 1'b0; i_hi_empty = 1'b1; i_lo_empty = 1'b1;
      i_hi_data = '0; i_lo_data = '0; i_frame_ready = 1'b0;
      i_tx_done = 1'b0; i_arb_lost = 1'b0; i_tx_error = 1'b0;
      rand_mode = 0; ready_low = 0;
      tick();
      check_en = 1;

      // Reset state
      reset_dut();
      checkOutput("rst_busy", o_busy, 1'b0);
      checkOutput("rst_valid", o_frame_valid, 1'b0);
      checkOutput("rst_frame", o_frame, '0);
      checkOutput("rst_src", o_src, 1'b0);
      checkOutput("rst_retry", o_retry_cnt, '0);
      checkOutput("rst_rd", {o_hi_rd_en, o_lo_rd_en, o_tx_ok, o_tx_abort}, 4'b0000);

      // Single lo frame: latency 3, one lo read, completes once
      $display("[TB] single lo frame");
      fa = 128'hA0A1_A2A3_A4A5_A6A7_A8A9_AAAB_ACAD_AEAF;
      push_lo(fa);
      ev_delay = 2;
      tick();
      i_enable = 1'b1;
      wait_valid(20, lat);
      checkOutput("t1_latency", lat, 3);
      checkOutput("t1_frame_at_valid", o_frame, fa);
      wait_events(1, 100, "t1_timeout");
      checkOutput("t1_lo_reads", n_lo_rd, 1);
      checkOutput("t1_hi_reads", n_hi_rd, 0);
      checkOutput("t1_ok_count", n_ok, 1);
      checkOutput("t1_ok_src", (ok_src_log.size() > 0) ? ok_src_log[0] : 1'bx, 1'b0);
      checkOutput("t1_ok_frame", (ok_frame_log.size() > 0) ? ok_frame_log[0] : 'x, fa);

      // Anti-starvation ordering: 6 hi + 2 lo -> H H H H L H H L
      $display("[TB] hi run ordering");
      reset_dut();
      for (int k = 0; k < 6; k++) push_hi(128'h1000 + k);
      push_lo(128'h2000);
      push_lo(128'h2001);
      i_enable = 1'b1;
      wait_events(8, 400, "t2_timeout");
      order = 8'b1111_0110;
      for (int k = 0; k < 8; k++)
         checkOutput($sformatf("t2_order%0d", k), (ok_src_log.size() > k) ? ok_src_log[k] : 1'bx, order[7-k]);
      checkOutput("t2_hi_reads", n_hi_rd, 6);
      checkOutput("t2_lo_reads", n_lo_rd, 2);

      // 15 errors then done: no abort, count reaches 15
      $display("[TB] fifteen errors then done");
      reset_dut();
      for (int k = 0; k < 15; k++) script_q.push_back("E");
      script_q.push_back("D");
      push_hi(128'h3333);
      i_enable = 1'b1;
      wait_events(1, 600, "t3_timeout");
      checkOutput("t3_max_retry", max_retry, 15);
      checkOutput("t3_ok_count", n_ok, 1);
      checkOutput("t3_abort_count", n_abort, 0);
      checkOutput("t3_retry_at_ok", ok_retry, 15);

      // 16 errors with 50 arbitration losses interleaved: abort at count 15
      $display("[TB] sixteen errors with arbitration losses");
      reset_dut();
      script_q.push_back("A");
      script_q.push_back("A");
      for (int k = 0; k < 16; k++) begin
         repeat (3) script_q.push_back("A");
         script_q.push_back("E");
      end
      push_lo(128'h4444);
      i_enable = 1'b1;
      wait_events(1, 3000, "t4_timeout");
      checkOutput("t4_abort_count", n_abort, 1);
      checkOutput("t4_ok_count", n_ok, 0);
      checkOutput("t4_retry_at_abort", abort_retry, 15);

      // Done and error together: done wins
      $display("[TB] simultaneous done and error");
      reset_dut();
      script_q.push_back("B");
      push_hi(128'h5555);
      i_enable = 1'b1;
      wait_events(1, 100, "t5_timeout");
      checkOutput("t5_ok_count", n_ok, 1);
      checkOutput("t5_abort_count", n_abort, 0);
      checkOutput("t5_retry_at_ok", ok_retry, 0);

      // Reset while waiting for the engine: everything clears, no pulse follows
      $display("[TB] reset during wait");
      reset_dut();
      ev_delay = 30;
      push_lo(128'h6666);
      i_enable = 1'b1;
      wait_valid(20, lat);
      tick();
      tick();
      checkOutput("t6_busy_before", o_busy, 1'b1);
      checkOutput("t6_valid_before", o_frame_valid, 1'b0);
      i_reset = 1'b1;
      tick();
      checkOutput("t6_busy_after", o_busy, 1'b0);
      checkOutput("t6_frame_after", o_frame, '0);
      checkOutput("t6_outs_after", {o_frame_valid, o_src, o_hi_rd_en, o_lo_rd_en, o_tx_ok, o_tx_abort}, 6'b0);
      checkOutput("t6_retry_after", o_retry_cnt, '0);
      i_reset = 1'b0;
      i_enable = 1'b0;
      repeat (50) tick();
      checkOutput("t6_no_ok", n_ok, 0);
      checkOutput("t6_no_abort", n_abort, 0);

      // Engine not ready for 20 cycles: offer held steady
      $display("[TB] back-pressure hold");
      reset_dut();
      ready_low = 1;
      tick();
      fx = 128'h7777_0000_1111_2222_3333_4444_5555_6666;
      push_hi(fx);
      i_enable = 1'b1;
      wait_valid(20, lat);
      checkOutput("t7_latency", lat, 3);
      f = o_frame;
      checkOutput("t7_frame", f, fx);
      for (int k = 0; k < 20; k++) begin
         tick();
         checkOutput("t7_hold_valid", o_frame_valid, 1'b1);
         checkOutput("t7_hold_frame", o_frame, fx);
      end
      ready_low = 0;
      wait_events(1, 100, "t7_timeout");
      checkOutput("t7_ok_frame", (ok_frame_log.size() > 0) ? ok_frame_log[0] : 'x, fx);

      // Random traffic, engine behaviour and occasional resets against the model
      $display("[TB] random traffic");
      reset_dut();
      rand_mode = 1;
      repeat (4000) tick();
      rand_mode = 0;
      i_reset = 1'b0;
      i_enable = 1'b1;
      ready_low = 0;
      ev_delay = 1;
      i = 0;
      while ((o_busy || hi_q.size() != 0 || lo_q.size() != 0) && i < 3000) begin
         if (o_busy && !o_frame_valid && cyc_n > fire_at) fire_at = cyc_n + 1;
         tick();
         i++;
      end
      checkOutput("rand_drained", !o_busy && hi_q.size() == 0 && lo_q.size() == 0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
